// File: rtl/sll_arbiter_pkg.sv
// Shared constants for the shift arbiter: datapath widths, requester IDs
// and the response-slot state encoding.
package sll_arbiter_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  // Requester identifiers as they appear on resp_id
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MD  = 1'b1;

  // The response slot is either empty or holding one result
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/shift_left_logical.sv
// Combinational logical left shift with zero fill; bits moved past the
// MSB are discarded.
module shift_left_logical #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result
);

  assign data_result = data_operandA << ctrl_shiftamt;

endmodule

// File: rtl/sll_arbiter.sv
// Round-robin arbiter sharing one shift_left_logical between two
// requesters. The result is held in a single registered slot; a new grant
// may issue in the same cycle the held result is accepted.
module sll_arbiter
  import sll_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_operandA,
  input  logic [SHAMT_W-1:0] req0_shiftamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_operandA,
  input  logic [SHAMT_W-1:0] req1_shiftamt,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_data,
  input  logic               resp_ready
);

  slot_state_t        state_reg, state_next;
  logic [WIDTH-1:0]   resp_data_reg, resp_data_next;
  logic               resp_id_reg, resp_id_next;
  logic               rr_ptr_reg, rr_ptr_next;

  logic               can_issue;
  logic               any_valid;
  logic               grant_id;
  logic               transfer;
  logic [1:0]         ready_vec;
  logic [WIDTH-1:0]   shift_operand;
  logic [SHAMT_W-1:0] shift_amount;
  logic [WIDTH-1:0]   shift_result;

  // The slot can take a new result if it is empty or being drained now
  assign can_issue = (state_reg == ST_EMPTY) | resp_ready;
  assign any_valid = req0_valid | req1_valid;

  // Contention goes to rr_ptr; otherwise whichever port is asking wins.
  // With no requester the grant defaults to port 0, but transfer is low.
  assign grant_id = (req0_valid & req1_valid) ? rr_ptr_reg : req1_valid;
  assign transfer = any_valid & can_issue & ~reset;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = transfer & (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // Shifter operands follow the winning port
  assign shift_operand = grant_id ? req1_operandA : req0_operandA;
  assign shift_amount  = grant_id ? req1_shiftamt : req0_shiftamt;

  shift_left_logical #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .data_operandA (shift_operand),
    .ctrl_shiftamt (shift_amount),
    .data_result   (shift_result)
  );

  // Next-state for the slot FSM, result payload and priority pointer
  always_comb begin
    state_next     = state_reg;
    resp_data_next = resp_data_reg;
    resp_id_next   = resp_id_reg;
    rr_ptr_next    = rr_ptr_reg;

    case (state_reg)
      ST_EMPTY: if (transfer) state_next = ST_FULL;
      ST_FULL:  if (resp_ready && !transfer) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase

    if (transfer) begin
      resp_data_next = shift_result;
      resp_id_next   = grant_id;
      rr_ptr_next    = ~grant_id;
    end
  end

  // State registers; reset drops any held result and restores port 0 priority
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_EMPTY;
      resp_data_reg <= '0;
      resp_id_reg   <= REQ_ALU;
      rr_ptr_reg    <= REQ_ALU;
    end else begin
      state_reg     <= state_next;
      resp_data_reg <= resp_data_next;
      resp_id_reg   <= resp_id_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign resp_valid = (state_reg == ST_FULL);
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_sll_arbiter.sv
// Directed bench for sll_arbiter with hand-computed expected values.
module tb_sll_arbiter;

  logic        clk;
  logic        srst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_operandA, req1_operandA;
  logic [4:0]  req0_shiftamt, req1_shiftamt;
  logic        resp_valid, resp_id, resp_ready;
  logic [31:0] resp_data;

  int checks   = 0;
  int failures = 0;

  sll_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock         (clk),
    .reset         (srst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_operandA (req0_operandA),
    .req0_shiftamt (req0_shiftamt),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_operandA (req1_operandA),
    .req1_shiftamt (req1_shiftamt),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_ready    (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s got=%08h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_data;
  logic        exp_id;

  initial begin
    srst = 1'b1;
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_operandA = '0; req0_shiftamt = '0;
    req1_operandA = '0; req1_shiftamt = '0;
    tick();
    // Ready must stay low during reset even with a request present
    req0_valid = 1; req0_operandA = 32'h1; req0_shiftamt = 5'd4;
    #1;
    check_val("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    tick();
    check_val("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_val("rst_resp_id",    {31'b0, resp_id},    32'd0);
    check_val("rst_resp_data",  resp_data,           32'd0);

    // Single requester: accepted same cycle, result one edge later
    srst = 0; resp_ready = 1;
    #1;
    check_val("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
    check_val("t1_req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0;
    check_val("t1_resp_valid", {31'b0, resp_valid}, 32'd1);
    check_val("t1_resp_id",    {31'b0, resp_id},    32'd0);
    check_val("t1_resp_data",  resp_data,           32'h00000010);
    tick();
    check_val("t1_drain_valid", {31'b0, resp_valid}, 32'd0);
    check_val("t1_drain_hold",  resp_data,           32'h00000010);

    // Fresh reset, then both requesters: port 0 first, then port 1, no bubble
    srst = 1;
    tick();
    srst = 0;
    req0_valid = 1; req0_operandA = 32'h0000000F; req0_shiftamt = 5'd28;
    req1_valid = 1; req1_operandA = 32'hFFFFFFFF; req1_shiftamt = 5'd31;
    #1;
    check_val("t2_first_req0_ready", {31'b0, req0_ready}, 32'd1);
    check_val("t2_first_req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    check_val("t2_first_data", resp_data, 32'hF0000000);
    check_val("t2_first_id",   {31'b0, resp_id}, 32'd0);
    check_val("t2_second_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    check_val("t2_second_valid", {31'b0, resp_valid}, 32'd1);
    check_val("t2_second_data",  resp_data, 32'h80000000);
    check_val("t2_second_id",    {31'b0, resp_id}, 32'd1);

    // Six held grants must alternate 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      exp_id   = i[0];
      exp_data = exp_id ? 32'h80000000 : 32'hF0000000;
      check_val($sformatf("t3_ready_%0d", i), {30'b0, req1_ready, req0_ready},
                exp_id ? 32'd2 : 32'd1);
      tick();
      check_val($sformatf("t3_id_%0d", i),   {31'b0, resp_id}, {31'b0, exp_id});
      check_val($sformatf("t3_data_%0d", i), resp_data, exp_data);
    end

    // Backpressure: held result stays put and req1 is refused
    resp_ready = 0; req0_valid = 0;
    req1_operandA = 32'h000000AB; req1_shiftamt = 5'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("t4_req1_ready_%0d", i), {31'b0, req1_ready}, 32'd0);
      tick();
      check_val($sformatf("t4_hold_valid_%0d", i), {31'b0, resp_valid}, 32'd1);
      check_val($sformatf("t4_hold_id_%0d", i),    {31'b0, resp_id},    32'd1);
      check_val($sformatf("t4_hold_data_%0d", i),  resp_data, 32'h80000000);
    end
    resp_ready = 1;
    #1;
    check_val("t4_release_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    check_val("t4_release_data", resp_data, 32'h0000AB00);
    check_val("t4_release_id",   {31'b0, resp_id}, 32'd1);

    // Shift amount boundaries
    req1_valid = 0;
    req0_valid = 1; req0_operandA = 32'h12345678; req0_shiftamt = 5'd0;
    #1;
    check_val("t5_amt0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    check_val("t5_amt0_data", resp_data, 32'h12345678);
    req0_operandA = 32'h80000001; req0_shiftamt = 5'd1;
    tick();
    check_val("t5_amt1_data", resp_data, 32'h00000002);
    req0_operandA = 32'h00000003; req0_shiftamt = 5'd31;
    tick();
    check_val("t5_amt31_data", resp_data, 32'h80000000);

    // Reset while FULL and stalled; rr_ptr currently favours port 1
    resp_ready = 0;
    req0_valid = 1; req0_operandA = 32'h00000005; req0_shiftamt = 5'd2;
    req1_valid = 1; req1_operandA = 32'h00000007; req1_shiftamt = 5'd3;
    srst = 1;
    #1;
    check_val("t6_rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    tick();
    check_val("t6_rst_valid", {31'b0, resp_valid}, 32'd0);
    srst = 0;
    #1;
    check_val("t6_after_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    check_val("t6_after_id",   {31'b0, resp_id}, 32'd0);
    check_val("t6_after_data", resp_data, 32'h00000014);
    tick();
    check_val("t6_drain_valid", {31'b0, resp_valid}, 32'd0);
    check_val("t6_drain_hold",  resp_data, 32'h00000014);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sll_arbiter.md
Name: sll_arbiter

Overview:
- Shares a single shift_left_logical datapath instance between two requesters (port 0: ALU issue, port 1: multdiv/immediate-gen helper).
- Round-robin arbitration over valid/ready request channels.
- The shift result is registered and returned on a per-requester response channel with backpressure.
- Single outstanding result; a new grant can issue in the same cycle the current result is accepted (full throughput: 1 shift/cycle).

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a shift request.
- req0_ready  out  1  request 0 accepted this cycle.
- req0_operandA  in  WIDTH  value to shift, requester 0.
- req0_shiftamt  in  SHAMT_W  shift amount, requester 0.
- req1_valid, req1_ready, req1_operandA, req1_shiftamt  same as above for requester 1.
- resp_valid  out  1  registered result present.
- resp_id  out  1  requester that owns resp_data (0/1).
- resp_data  out  WIDTH  operandA << shiftamt, zero fill.
- resp_ready  in  1  owner accepts result; sampled only when resp_valid=1.

Behaviour:
- Reset (sync, active-high): resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0 (port 0 has priority first). req*_ready=0 while reset is high.
- can_issue = ~resp_valid | resp_ready.
- Arbitration (combinational, same cycle):
  - If only one reqN_valid is high, it wins.
  - If both are high, the port equal to rr_ptr wins.
  - If neither is high, no grant.
- reqN_ready = can_issue & granted(N) & ~reset. A transfer occurs when reqN_valid & reqN_ready.
- Shared shifter inputs are muxed from the winning port (port 0 when idle). Outputs must not depend on the idle mux value.
- On a transfer (registered, next edge):
  - resp_data <= shifter result.
  - resp_id <= N.
  - resp_valid <= 1.
  - rr_ptr <= ~N (the loser gets priority next).
- Latency: request accepted at edge k, resp_valid=1 after edge k+1 with data valid in that cycle.
- If resp_valid & resp_ready and no transfer: resp_valid <= 0. resp_data and resp_id hold their last value.
- If resp_valid & ~resp_ready: resp_valid, resp_data and resp_id are held stable, and both req*_ready=0 (backpressure).
- Simultaneous accept + new transfer: resp_valid stays 1 and is reloaded with the new result. No bubble.
- rr_ptr changes only on a transfer. An unchallenged single requester does not consume the other's priority.
- Requesters must hold operandA/shiftamt stable while valid and not ready. The arbiter does not re-sample after grant.
- Shift arithmetic: logical left shift, zero fill, bits shifted beyond WIDTH-1 are discarded. shiftamt=0 passes the operand through unchanged.
- Reset asserted mid-operation: any pending resp is dropped (resp_valid=0 next edge), rr_ptr returns to 0, and no transfer occurs during reset.
- Two-state FSM is implied by resp_valid:
  - EMPTY (resp_valid=0): stays EMPTY with no transfer; goes to FULL on a transfer.
  - FULL (resp_valid=1): stays FULL on stall or on accept+transfer; goes to EMPTY on accept with no transfer.

Decomposition:
- Shared include (cpu_defs): WIDTH=32, SHAMT_W=5, and requester ID constants REQ_ALU=0, REQ_MD=1.
- One sub-module: the existing shift_left_logical (data_operandA, ctrl_shiftamt, data_result), instantiated once.
- Arbitration, response register and rr_ptr live in sll_arbiter itself.

Test Plan:
- Reset, then req0 only, A=0x00000001, amt=4 → req0_ready=1 in the same cycle; next cycle resp_valid=1, resp_id=0, resp_data=0x00000010.
- Both valid from reset (req0 A=0x0000000F amt=28, req1 A=0xFFFFFFFF amt=31) with resp_ready=1 → port 0 granted first (resp_data=0xF0000000), then port 1 (0x80000000). Back-to-back, no bubble.
- Both requesters held valid for 6 cycles with resp_ready=1 → grants strictly alternate 0,1,0,1,0,1.
- resp_ready=0 for 3 cycles while FULL with req1 valid → resp_data/resp_id stable, req1_ready=0. Raising resp_ready issues req1 that same cycle.
- Edge amounts: A=0x12345678, amt=0 → 0x12345678; A=0x80000001, amt=1 → 0x00000002.
- Reset pulsed while FULL with resp_ready=0 → resp_valid=0 next cycle, rr_ptr=0; with both requesters valid afterwards, port 0 wins first.
